// File: rtl/lfsr_period_checker_pkg.sv
// Shared types and constants for the LFSR period checker: FSM encoding,
// default state width and the maximal-period helper.
package lfsr_period_checker_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int MAXP      = (1 << WIDTH_DEF) - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic int maxp(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/lfsr_period_checker_seen_bitmap.sv
// One flag per possible LFSR state; set on first sighting, tested combinationally.
// Latency: set visible the cycle after the set edge; backpressure: none (no handshake).
module seen_bitmap #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             set,
  input  logic [WIDTH-1:0] set_idx,
  input  logic [WIDTH-1:0] test_idx,
  output logic             hit
);

  logic [(1<<WIDTH)-1:0] bits;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      bits <= '0;
    end else if (set) begin
      bits[set_idx] <= 1'b1;
    end
  end

  assign hit = bits[test_idx];

endmodule

// File: rtl/lfsr_period_checker.sv
// Measures the period of a sampled LFSR stream and flags lock-up / non-seed repeats.
// Latency: results visible one cycle after the closing sample; backpressure: none, samples gated by in_valid.
module lfsr_period_checker
  import lfsr_period_checker_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             in_valid,
  input  logic [1:WIDTH]   din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   period,
  output logic             maximal,
  output logic             err_lockup,
  output logic             err_repeat
);

  localparam logic [WIDTH:0] MAXP_W = (WIDTH+1)'(maxp(WIDTH));

  state_t           state, state_n;
  logic [WIDTH-1:0] seed, seed_n;
  logic [WIDTH:0]   cnt, cnt_n;
  logic [WIDTH:0]   period_n;
  logic             lock_n, rep_n;
  logic             bm_clr, bm_set, bm_hit;
  logic [WIDTH-1:0] d;

  assign d = din;

  seen_bitmap #(.WIDTH(WIDTH)) u_seen (
    .clk      (CLK),
    .rst      (RST),
    .clr      (bm_clr),
    .set      (bm_set),
    .set_idx  (d),
    .test_idx (d),
    .hit      (bm_hit)
  );

  always_comb begin
    state_n  = state;
    seed_n   = seed;
    cnt_n    = cnt;
    period_n = period;
    lock_n   = err_lockup;
    rep_n    = err_repeat;
    bm_clr   = 1'b0;
    bm_set   = 1'b0;

    // start always wins, including over a coincident sample
    if (start) begin
      state_n  = ARM;
      seed_n   = '0;
      cnt_n    = '0;
      period_n = '0;
      lock_n   = 1'b0;
      rep_n    = 1'b0;
      bm_clr   = 1'b1;
    end else begin
      case (state)
        ARM: begin
          if (in_valid) begin
            if (d == '0) begin
              lock_n   = 1'b1;
              period_n = '0;
              state_n  = DONE;
            end else begin
              seed_n  = d;
              bm_set  = 1'b1;
              cnt_n   = (WIDTH+1)'(1);
              state_n = MEASURE;
            end
          end
        end
        MEASURE: begin
          if (in_valid) begin
            if (d == seed) begin
              period_n = cnt;
              state_n  = DONE;
            end else if (d == '0) begin
              lock_n   = 1'b1;
              period_n = '0;
              state_n  = DONE;
            end else if (bm_hit) begin
              rep_n    = 1'b1;
              period_n = '0;
              state_n  = DONE;
            end else begin
              bm_set = 1'b1;
              cnt_n  = cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= IDLE;
      seed       <= '0;
      cnt        <= '0;
      period     <= '0;
      maximal    <= 1'b0;
      err_lockup <= 1'b0;
      err_repeat <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      seed       <= seed_n;
      cnt        <= cnt_n;
      period     <= period_n;
      maximal    <= (state_n == DONE) && (period_n == MAXP_W);
      err_lockup <= lock_n;
      err_repeat <= rep_n;
      busy       <= (state_n == ARM) || (state_n == MEASURE);
      done       <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_lfsr_period_checker.sv
// Directed bench for lfsr_period_checker with hand-computed expectations.
module tb_lfsr_period_checker;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:4] din = 4'b0000;
  logic       busy, done, maximal, err_lockup, err_repeat;
  logic [4:0] period;

  int checks = 0;
  int errors = 0;

  // maximal sequence of s' = {s[2:0], s[3]^s[2]} from seed 0001
  logic [3:0] mseq [0:14] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011,
                              4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011,
                              4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

  lfsr_period_checker #(.WIDTH(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .in_valid   (in_valid),
    .din        (din),
    .busy       (busy),
    .done       (done),
    .period     (period),
    .maximal    (maximal),
    .err_lockup (err_lockup),
    .err_repeat (err_repeat)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic samp(input logic [3:0] v);
    in_valid = 1'b1;
    din      = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic results(input string tag, input int p, input logic m,
                         input logic l, input logic r);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_period"}, period, p);
    chk({tag, "_maximal"}, maximal, m);
    chk({tag, "_lockup"}, err_lockup, l);
    chk({tag, "_repeat"}, err_repeat, r);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_period", period, 0);
    chk("rst_flags", {maximal, err_lockup, err_repeat}, 0);
    RST = 1'b1;
    tick();

    // maximal sequence, back to back
    pulse_start();
    chk("arm_busy", busy, 1);
    for (int i = 0; i < 15; i++) begin
      samp(mseq[i]);
      chk("max_running", {busy, done}, 2'b10);
    end
    samp(4'b0001);
    results("max", 15, 1, 0, 0);
    samp(4'b0010);
    chk("done_ignores_valid", period, 15);

    // short cycle of two
    pulse_start();
    chk("restart_done", done, 0);
    samp(4'b1010); samp(4'b0101); samp(4'b1010);
    results("short", 2, 0, 0, 0);

    // repeat of a non-seed state
    pulse_start();
    samp(4'b0011); samp(4'b0101); samp(4'b0110);
    chk("rep_pre", done, 0);
    samp(4'b0101);
    results("repeat", 0, 0, 0, 1);

    // lock-up on first and third samples
    pulse_start();
    samp(4'b0000);
    results("lock1", 0, 0, 1, 0);
    pulse_start();
    samp(4'b0011); samp(4'b0101);
    samp(4'b0000);
    results("lock3", 0, 0, 1, 0);

    // maximal sequence with gaps between samples
    pulse_start();
    for (int i = 0; i < 15; i++) begin
      samp(mseq[i]);
      tick();
      chk("gap_running", {busy, done}, 2'b10);
    end
    samp(4'b0001);
    results("gap", 15, 1, 0, 0);

    // abort after five samples; bitmap and seed must be fresh
    pulse_start();
    for (int i = 0; i < 5; i++) samp(mseq[i]);
    pulse_start();
    chk("abort_busy", busy, 1);
    chk("abort_clear", {done, period, err_lockup, err_repeat}, 0);
    samp(4'b0100); samp(4'b1001); samp(4'b0100);
    results("abort", 2, 0, 0, 0);

    // start with a coincident zero sample: sample discarded
    start = 1'b1; in_valid = 1'b1; din = 4'b0000;
    tick();
    start = 1'b0; in_valid = 1'b0;
    chk("coinc_busy", busy, 1);
    chk("coinc_lockup", err_lockup, 0);
    samp(4'b0011); samp(4'b0101); samp(4'b0011);
    results("coinc", 2, 0, 0, 0);

    // reset mid-measurement
    pulse_start();
    samp(4'b0001); samp(4'b0010);
    RST = 1'b0;
    tick();
    chk("midrst_outs", {busy, done, period, maximal, err_lockup, err_repeat}, 0);
    RST = 1'b1;
    samp(4'b0001);
    chk("idle_ignores_valid", {busy, done}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 exp 1");
    $fatal(1);
  end

endmodule
